hd_program_loader: RTL and testbench
====================================

// Module: hd_program_loader
// PURPOSE
//  Reader for the simulated HD image: on request, walks the HD RAM from address 0,
//  validates the HD_HEAD marker, seeks the Nth BEGIN_FILE..END_FILE section and
//  copies its body words into instruction memory starting at IM address 0.
//  Sits between HDSimulado (read port) and the instruction RAM write port; driven by the OS/boot control.
//  Markers are identified by word[31:26]: HD_HEAD=6'b010111, BEGIN_FILE=6'b010101,
//  END_FILE=6'b010110, HD_END=6'b011000; all other words are file body.
// PARAMETERS
//  DATA_WIDTH      32  HD/IM word width
//  HD_ADDR_WIDTH   9   HD address width (2**HD_ADDR_WIDTH words)
//  IM_ADDR_WIDTH   9   instruction memory address width
//  FILE_IDX_WIDTH  4   width of file index request
// PORTS
//  clk       in   1               clock, all logic on posedge
//  rst       in   1               synchronous, active-high reset
//  start     in   1               load request, sampled in IDLE only
//  file_idx  in   FILE_IDX_WIDTH  0-based index of file to load, captured with start
//  hd_addr   out  HD_ADDR_WIDTH   HD read address (HD returns data 1 cycle later)
//  hd_q      in   DATA_WIDTH      HD read data
//  im_addr   out  IM_ADDR_WIDTH   IM write address
//  im_data   out  DATA_WIDTH      IM write data
//  im_we     out  1               IM write enable
//  busy      out  1               high from cycle after accepted start until done
//  done      out  1               1-cycle pulse at end of load (success or error)
//  err_code  out  2               0 ok, 1 no HD_HEAD, 2 file not found, 3 overflow/format
//  file_len  out  IM_ADDR_WIDTH+1 number of words written
//  checksum  out  DATA_WIDTH      see CONFIGURATION
// BEHAVIOUR
//  - Reset: state IDLE; hd_addr, im_addr, im_data, file_len, checksum = 0; im_we, busy, done = 0; err_code = 0.
//  - All outputs registered. rst wins over any simultaneous start; mid-load reset aborts: im_we=0 from next cycle.
//  - FSM: IDLE -> HEAD -> SEEK -> COPY -> FIN -> IDLE; any error -> FIN with err_code set.
//  - Streaming read: start accepted at cycle 0 (edge); hd_addr=0 in cycle 1, +1 per cycle while busy;
//    word at address a is evaluated in cycle a+2. Write of a body word at address a: im_we=1 in cycle a+3.
//  - HEAD: word 0 != HD_HEAD -> err 1. SEEK: counts BEGIN_FILE; the (file_idx)th one enters COPY;
//    HD_END seen first -> err 2. Body words in SEEK are skipped.
//  - COPY: each body word written to im_addr = file_len, then file_len++. END_FILE -> success.
//    BEGIN_FILE, HD_END or HD_HEAD in COPY -> err 3. Write past 2**IM_ADDR_WIDTH words -> err 3, no write.
//  - hd_addr reaching 2**HD_ADDR_WIDTH-1 without terminating marker -> err 3 (no wrap to 0).
//  - Terminating word at address e -> done=1 in cycle e+3, busy falls same cycle, hd_addr frozen.
//  - err_code, file_len, checksum held until next accepted start (cleared on it). start while busy ignored.
//  - im_we never asserted for marker words or on error cycles; partial writes before an error remain.
// CONFIGURATION
//  HDLOAD_CHECKSUM_EN defined: checksum = 32-bit wrapping sum of all words written in the load,
//   updated with each im_we. Undefined: checksum tied to 0, no adder synthesized.
// TESTING (HD preloaded with the team boot image: HEAD@0, BEGIN@1, body 2..32, END@33, HD_END@34)
//  1 start, file_idx=0 -> 31 writes im[0]=0x08010004 .. im[30]=0x1400001E; done cycle 36, err 0, file_len 31.
//  2 start, file_idx=1 -> no im_we; done cycle 37, err_code 2, file_len 0.
//  3 word0 overwritten 0x00000000, start -> done cycle 3, err_code 1, no im_we.
//  4 IM_ADDR_WIDTH=4, file_idx=0 -> 16 writes, err_code 3, file_len 16, 17th word not written.
//  5 rst=1 at cycle 15 of test 1 -> im_we=0, busy=0 next cycle; re-start then repeats test 1 exactly;
//    start pulsed during busy ignored.
//  6 HDLOAD_CHECKSUM_EN, test 1 -> checksum equals model sum mod 2**32 of ram[2..32]; undefined -> 0.

Source files
------------

// File: rtl/hd_program_loader_if.sv
// Signal bundle between the program loader, its controller, the HD read port and the IM write port.
// The loader takes the slave modport; the side that drives start/file_idx/hd_q takes master.
interface hd_program_loader_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int HD_ADDR_WIDTH  = 9,
    parameter int IM_ADDR_WIDTH  = 9,
    parameter int FILE_IDX_WIDTH = 4
);
    logic                      start;
    logic [FILE_IDX_WIDTH-1:0] file_idx;
    logic [HD_ADDR_WIDTH-1:0]  hd_addr;
    logic [DATA_WIDTH-1:0]     hd_q;
    logic [IM_ADDR_WIDTH-1:0]  im_addr;
    logic [DATA_WIDTH-1:0]     im_data;
    logic                      im_we;
    logic                      busy;
    logic                      done;
    logic [1:0]                err_code;
    logic [IM_ADDR_WIDTH:0]    file_len;
    logic [DATA_WIDTH-1:0]     checksum;

    modport master (
        output start, file_idx, hd_q,
        input  hd_addr, im_addr, im_data, im_we, busy, done, err_code, file_len, checksum
    );

    modport slave (
        input  start, file_idx, hd_q,
        output hd_addr, im_addr, im_data, im_we, busy, done, err_code, file_len, checksum
    );
endinterface

// File: rtl/hd_program_loader.sv
// Streams the HD image from address 0, finds the Nth BEGIN_FILE..END_FILE section and copies its body into IM.
// Define HDLOAD_CHECKSUM_EN to get a running 32-bit sum of the written words on checksum; otherwise it is tied to 0.
module hd_program_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int HD_ADDR_WIDTH  = 9,
    parameter int IM_ADDR_WIDTH  = 9,
    parameter int FILE_IDX_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    hd_program_loader_if.slave ld
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_SEEK,
        S_COPY,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK        = 2'd0,
        ERR_NO_HEAD   = 2'd1,
        ERR_NOT_FOUND = 2'd2,
        ERR_FORMAT    = 2'd3
    } err_t;

    localparam logic [5:0] OP_BEGIN  = 6'b010101;
    localparam logic [5:0] OP_END    = 6'b010110;
    localparam logic [5:0] OP_HEAD   = 6'b010111;
    localparam logic [5:0] OP_HD_END = 6'b011000;

    localparam logic [HD_ADDR_WIDTH-1:0] HD_LAST = '1;

    state_t                    r_state;
    state_t                    w_state_next;

    logic [HD_ADDR_WIDTH-1:0]  r_hd_addr;
    logic [HD_ADDR_WIDTH-1:0]  r_q_addr;
    logic                      r_q_vld;
    logic [FILE_IDX_WIDTH-1:0] r_file_idx;
    logic [FILE_IDX_WIDTH-1:0] r_begin_cnt;
    logic [IM_ADDR_WIDTH-1:0]  r_im_addr;
    logic [DATA_WIDTH-1:0]     r_im_data;
    logic                      r_im_we;
    logic                      r_busy;
    logic                      r_done;
    err_t                      r_err;
    logic [IM_ADDR_WIDTH:0]    r_file_len;

    logic [5:0]                w_op;
    logic                      w_is_begin;
    logic                      w_is_end;
    logic                      w_is_head;
    logic                      w_is_hd_end;
    logic                      w_is_marker;
    logic                      w_at_last;
    logic                      w_im_full;

    logic                      w_accept;
    logic                      w_fin;
    err_t                      w_err;
    logic                      w_write;
    logic                      w_enter_copy;
    logic                      w_count_begin;

    // Word classification of the HD word currently on hd_q (valid when r_q_vld).
    assign w_op        = ld.hd_q[DATA_WIDTH-1 -: 6];
    assign w_is_begin  = (w_op == OP_BEGIN);
    assign w_is_end    = (w_op == OP_END);
    assign w_is_head   = (w_op == OP_HEAD);
    assign w_is_hd_end = (w_op == OP_HD_END);
    assign w_is_marker = w_is_begin | w_is_hd_end | w_is_head;
    assign w_at_last   = (r_q_addr == HD_LAST);
    assign w_im_full   = r_file_len[IM_ADDR_WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_HEAD;
            S_HEAD: begin
                if (w_fin)        w_state_next = S_FIN;
                else if (r_q_vld) w_state_next = S_SEEK;
            end
            S_SEEK: begin
                if (w_fin)             w_state_next = S_FIN;
                else if (w_enter_copy) w_state_next = S_COPY;
            end
            S_COPY: if (w_fin) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Per-word decisions; the address check stops the walk at the last HD word instead of wrapping.
    always_comb begin
        w_accept      = 1'b0;
        w_fin         = 1'b0;
        w_err         = ERR_OK;
        w_write       = 1'b0;
        w_enter_copy  = 1'b0;
        w_count_begin = 1'b0;
        case (r_state)
            S_IDLE: w_accept = ld.start;
            S_HEAD: begin
                if (r_q_vld) begin
                    if (!w_is_head) begin
                        w_fin = 1'b1;
                        w_err = ERR_NO_HEAD;
                    end else if (w_at_last) begin
                        w_fin = 1'b1;
                        w_err = ERR_FORMAT;
                    end
                end
            end
            S_SEEK: begin
                if (r_q_vld) begin
                    if (w_is_hd_end) begin
                        w_fin = 1'b1;
                        w_err = ERR_NOT_FOUND;
                    end else if (w_at_last) begin
                        w_fin = 1'b1;
                        w_err = ERR_FORMAT;
                    end else if (w_is_begin) begin
                        if (r_begin_cnt == r_file_idx) w_enter_copy  = 1'b1;
                        else                           w_count_begin = 1'b1;
                    end
                end
            end
            S_COPY: begin
                if (r_q_vld) begin
                    if (w_is_end) begin
                        w_fin = 1'b1;
                    end else if (w_is_marker || w_at_last || w_im_full) begin
                        w_fin = 1'b1;
                        w_err = ERR_FORMAT;
                    end else begin
                        w_write = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Read pointer, result registers and IM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hd_addr   <= '0;
            r_q_addr    <= '0;
            r_q_vld     <= 1'b0;
            r_file_idx  <= '0;
            r_begin_cnt <= '0;
            r_im_addr   <= '0;
            r_im_data   <= '0;
            r_im_we     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= ERR_OK;
            r_file_len  <= '0;
        end else begin
            r_im_we <= w_write;
            r_done  <= w_fin;
            if (w_accept) begin
                r_busy      <= 1'b1;
                r_hd_addr   <= '0;
                r_q_vld     <= 1'b0;
                r_file_idx  <= ld.file_idx;
                r_begin_cnt <= '0;
                r_err       <= ERR_OK;
                r_file_len  <= '0;
            end else if (w_fin) begin
                r_busy  <= 1'b0;
                r_q_vld <= 1'b0;
                r_err   <= w_err;
            end else if (r_busy) begin
                r_q_addr <= r_hd_addr;
                r_q_vld  <= 1'b1;
                if (r_hd_addr != HD_LAST) r_hd_addr <= r_hd_addr + HD_ADDR_WIDTH'(1);
            end
            if (w_count_begin) r_begin_cnt <= r_begin_cnt + FILE_IDX_WIDTH'(1);
            if (w_write) begin
                r_im_addr  <= r_file_len[IM_ADDR_WIDTH-1:0];
                r_im_data  <= ld.hd_q;
                r_file_len <= r_file_len + (IM_ADDR_WIDTH+1)'(1);
            end
        end
    end

`ifdef HDLOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (w_write) begin
            r_checksum <= r_checksum + ld.hd_q;
        end
    end

    assign ld.checksum = r_checksum;
`else
    assign ld.checksum = '0;
`endif

    assign ld.hd_addr  = r_hd_addr;
    assign ld.im_addr  = r_im_addr;
    assign ld.im_data  = r_im_data;
    assign ld.im_we    = r_im_we;
    assign ld.busy     = r_busy;
    assign ld.done     = r_done;
    assign ld.err_code = r_err;
    assign ld.file_len = r_file_len;
endmodule

// File: tb/tb_hd_program_loader.sv
// Bench for hd_program_loader: two instances (512-word and 16-word IM) share one HD image and are
// compared against a file-scanning reference model on the boot image and on random images.
module tb_hd_program_loader;
    localparam int MAXA   = 511;
    localparam int CAP_A  = 512;
    localparam int CAP_B  = 16;
    localparam int BUDGET = 700;

    localparam logic [5:0] OP_BEGIN  = 6'b010101;
    localparam logic [5:0] OP_END    = 6'b010110;
    localparam logic [5:0] OP_HEAD   = 6'b010111;
    localparam logic [5:0] OP_HD_END = 6'b011000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] ram [512];

    hd_program_loader_if #(.DATA_WIDTH(32), .HD_ADDR_WIDTH(9), .IM_ADDR_WIDTH(9), .FILE_IDX_WIDTH(4)) if_a ();
    hd_program_loader_if #(.DATA_WIDTH(32), .HD_ADDR_WIDTH(9), .IM_ADDR_WIDTH(4), .FILE_IDX_WIDTH(4)) if_b ();

    hd_program_loader #(.DATA_WIDTH(32), .HD_ADDR_WIDTH(9), .IM_ADDR_WIDTH(9), .FILE_IDX_WIDTH(4)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .ld  (if_a)
    );

    hd_program_loader #(.DATA_WIDTH(32), .HD_ADDR_WIDTH(9), .IM_ADDR_WIDTH(4), .FILE_IDX_WIDTH(4)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .ld  (if_b)
    );

    // HD: synchronous read, data one cycle after the address.
    always @(posedge clk) begin
        if_a.hd_q <= ram[if_a.hd_addr];
        if_b.hd_q <= ram[if_b.hd_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    int          obs_a0[$];
    int          obs_a1[$];
    logic [31:0] obs_d0[$];
    logic [31:0] obs_d1[$];
    bit          seen[2];
    int          done_cyc[2];
    logic [1:0]  err_o[2];
    logic [9:0]  len_o[2];
    logic [31:0] cks_o[2];
    logic [8:0]  hda_o[2];
    logic        busy_o[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mark(input logic [31:0] w);
        return (w[31:26] >= 6'd21) && (w[31:26] <= 6'd24);
    endfunction

    function automatic logic [31:0] rand_body();
        logic [31:0] w;
        w = $urandom;
        while (is_mark(w)) w[31:26] = 6'($urandom_range(0, 63));
        return w;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 26'($urandom)};
    endfunction

    // Reference: scan the image as a file system, not as a pipeline.
    function automatic void model(input int idx, input int cap, output int err, output int term,
                                  output int first, output int n);
        int cnt;
        err = 0; term = 0; first = -1; n = 0;
        if (ram[0][31:26] != OP_HEAD) begin
            err = 1;
            return;
        end
        cnt = 0;
        for (int a = 1; first < 0; a++) begin
            if (ram[a][31:26] == OP_HD_END) begin err = 2; term = a; return; end
            if (a == MAXA) begin err = 3; term = a; return; end
            if (ram[a][31:26] == OP_BEGIN) begin
                if (cnt == idx) first = a + 1;
                cnt++;
            end
        end
        for (int a = first; ; a++) begin
            if (ram[a][31:26] == OP_END) begin term = a; return; end
            if (is_mark(ram[a]) || a == MAXA || n == cap) begin err = 3; term = a; return; end
            n++;
        end
    endfunction

    task automatic build_boot();
        for (int a = 0; a < 512; a++) ram[a] = rand_body();
        ram[0] = mk(OP_HEAD);
        ram[1] = mk(OP_BEGIN);
        ram[2] = 32'h0801_0004;
        ram[32] = 32'h1400_001E;
        ram[33] = mk(OP_END);
        ram[34] = mk(OP_HD_END);
    endtask

    // mode 0: clean image, 1: one stray marker somewhere, 2: no HD_END (walk runs to the last word).
    task automatic build_random(input int nfiles, input int mode);
        int a;
        logic [5:0] ops [4];
        ops[0] = OP_BEGIN; ops[1] = OP_END; ops[2] = OP_HEAD; ops[3] = OP_HD_END;
        for (int i = 0; i < 512; i++) ram[i] = rand_body();
        ram[0] = mk(OP_HEAD);
        a = 1;
        for (int f = 0; f < nfiles; f++) begin
            a += $urandom_range(0, 3);
            ram[a] = mk(OP_BEGIN);
            a += 1 + $urandom_range(0, 24);
            ram[a] = mk(OP_END);
            a++;
        end
        if (mode != 2) ram[a] = mk(OP_HD_END);
        if (mode == 1) ram[$urandom_range(2, a)] = mk(ops[$urandom_range(0, 3)]);
    endtask

    task automatic drive(input logic s, input int idx);
        if_a.start    = s;
        if_b.start    = s;
        if_a.file_idx = 4'(idx);
        if_b.file_idx = 4'(idx);
    endtask

    task automatic sample(input int cyc);
        if (if_a.im_we) begin obs_a0.push_back(int'(if_a.im_addr)); obs_d0.push_back(if_a.im_data); end
        if (if_b.im_we) begin obs_a1.push_back(int'(if_b.im_addr)); obs_d1.push_back(if_b.im_data); end
        if (if_a.done && !seen[0]) begin
            seen[0] = 1'b1; done_cyc[0] = cyc; err_o[0] = if_a.err_code; len_o[0] = if_a.file_len;
            cks_o[0] = if_a.checksum; hda_o[0] = if_a.hd_addr; busy_o[0] = if_a.busy;
        end
        if (if_b.done && !seen[1]) begin
            seen[1] = 1'b1; done_cyc[1] = cyc; err_o[1] = if_b.err_code; len_o[1] = {5'd0, if_b.file_len};
            cks_o[1] = if_b.checksum; hda_o[1] = if_b.hd_addr; busy_o[1] = if_b.busy;
        end
    endtask

    // Start a load at edge 0; cycle k is observed at the falling edge after edge k-1.
    task automatic run_load(input string name, input int idx, input int pulse_at, input int abort_at);
        int cyc;
        int e_err, e_term, e_first, e_n, hd_exp;
        logic [31:0] e_sum;
        int qa[$];
        logic [31:0] qd[$];
        obs_a0.delete(); obs_a1.delete(); obs_d0.delete(); obs_d1.delete();
        seen[0] = 1'b0; seen[1] = 1'b0;
        done_cyc[0] = 0; done_cyc[1] = 0;
        @(negedge clk);
        drive(1'b1, idx);
        @(negedge clk);
        drive(1'b0, idx);
        cyc = 1;
        check({name, "/a.hd_addr@1"}, 64'(if_a.hd_addr), 64'd0);
        check({name, "/a.busy@1"},    64'(if_a.busy),    64'd1);
        while (!(seen[0] && seen[1]) && cyc < BUDGET) begin
            sample(cyc);
            if (cyc == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({name, "/a.im_we_after_rst"}, 64'(if_a.im_we), 64'd0);
                check({name, "/a.busy_after_rst"},  64'(if_a.busy),  64'd0);
                check({name, "/b.busy_after_rst"},  64'(if_b.busy),  64'd0);
                return;
            end
            if (cyc == pulse_at) drive(1'b1, idx + 1);
            else                 drive(1'b0, idx);
            @(negedge clk);
            cyc++;
        end
        drive(1'b0, idx);
        for (int k = 0; k < 2; k++) begin
            string p;
            p = (k == 0) ? {name, "/a"} : {name, "/b"};
            model(idx, (k == 0) ? CAP_A : CAP_B, e_err, e_term, e_first, e_n);
            e_sum = '0;
            for (int i = 0; i < e_n; i++) e_sum += ram[e_first + i];
`ifndef HDLOAD_CHECKSUM_EN
            e_sum = '0;
`endif
            hd_exp = (e_term + 1 > MAXA) ? MAXA : e_term + 1;
            check({p, ".done_seen"}, 64'(seen[k]),     64'd1);
            check({p, ".done_cyc"},  64'(done_cyc[k]), 64'(e_term + 3));
            check({p, ".err_code"},  64'(err_o[k]),    64'(e_err));
            check({p, ".file_len"},  64'(len_o[k]),    64'(e_n));
            check({p, ".checksum"},  64'(cks_o[k]),    64'(e_sum));
            check({p, ".busy@done"}, 64'(busy_o[k]),   64'd0);
            check({p, ".hd_addr@done"}, 64'(hda_o[k]), 64'(hd_exp));
            if (k == 0) begin qa = obs_a0; qd = obs_d0; end
            else        begin qa = obs_a1; qd = obs_d1; end
            check({p, ".n_writes"}, 64'(qa.size()), 64'(e_n));
            for (int i = 0; i < qa.size() && i < e_n; i++) begin
                check({p, ".im_addr"}, 64'(qa[i]), 64'(i));
                check({p, ".im_data"}, 64'(qd[i]), 64'(ram[e_first + i]));
            end
        end
        repeat (2) @(negedge clk);
        check({name, "/a.err_held"}, 64'(if_a.err_code), 64'(err_o[0]));
        check({name, "/b.len_held"}, 64'(if_b.file_len), 64'(len_o[1]));
        check({name, "/a.done_pulse"}, 64'(if_a.done), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w0;
        drive(1'b0, 0);
        build_boot();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst/a.hd_addr",  64'(if_a.hd_addr),  64'd0);
        check("rst/a.im_addr",  64'(if_a.im_addr),  64'd0);
        check("rst/a.im_data",  64'(if_a.im_data),  64'd0);
        check("rst/a.im_we",    64'(if_a.im_we),    64'd0);
        check("rst/a.busy",     64'(if_a.busy),     64'd0);
        check("rst/a.done",     64'(if_a.done),     64'd0);
        check("rst/a.err_code", 64'(if_a.err_code), 64'd0);
        check("rst/a.file_len", 64'(if_a.file_len), 64'd0);
        check("rst/a.checksum", 64'(if_a.checksum), 64'd0);
        check("rst/b.busy",     64'(if_b.busy),     64'd0);
        // Reset wins over a simultaneous start.
        drive(1'b1, 0);
        @(negedge clk);
        check("rst/start_blocked", 64'(if_a.busy), 64'd0);
        drive(1'b0, 0);
        rst = 1'b0;

        run_load("boot_f0", 0, -1, -1);
        run_load("boot_f1", 1, -1, -1);
        w0 = ram[0];
        ram[0] = 32'h0000_0000;
        run_load("no_head", 0, -1, -1);
        ram[0] = w0;
        run_load("abort", 0, -1, 15);
        run_load("restart", 0, 10, -1);

        for (int t = 0; t < 9; t++) begin
            int nf;
            nf = $urandom_range(1, 5);
            build_random(nf, t % 3);
            run_load($sformatf("rand%0d", t), $urandom_range(0, nf), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
